// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS controller
// Purpose: FSM state enum, opcodes, C-type function codes, ALU op codes and
//          datapath selector encodings used by the controller and its datapath.
// Ports:   none (package).
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_RD,
      S_LOAD_WB,
      S_MEM_WR,
      S_JMP,
      S_BRZ,
      S_C_EXEC,
      S_C_WB,
      S_I_EXEC,
      S_I_WB
   } state_t;

   // Which decode rule the ALU control applies in the current state.
   typedef enum logic [2:0] {
      ALU_CLS_NONE,
      ALU_CLS_FETCH,
      ALU_CLS_BRZ,
      ALU_CLS_C,
      ALU_CLS_I
   } alu_class_t;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_JUMP  = 4'b0010;
   localparam logic [3:0] OP_BRZ   = 4'b0100;
   localparam logic [3:0] OP_CTYPE = 4'b1000;
   localparam logic [3:0] OP_ADDI  = 4'b1100;
   localparam logic [3:0] OP_SUBI  = 4'b1101;
   localparam logic [3:0] OP_ANDI  = 4'b1110;

   localparam logic [2:0] FN_MOVETO   = 3'b000;
   localparam logic [2:0] FN_MOVEFROM = 3'b001;
   localparam logic [2:0] FN_ADD      = 3'b010;
   localparam logic [2:0] FN_SUB      = 3'b011;
   localparam logic [2:0] FN_AND      = 3'b100;
   localparam logic [2:0] FN_NOT      = 3'b101;
   localparam logic [2:0] FN_NOP0     = 3'b110;
   localparam logic [2:0] FN_NOP1     = 3'b111;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_AND    = 2'b10;
   localparam logic [1:0] ALU_PASS_A = 2'b11;

   localparam logic MEM_ADR_INST = 1'b0;
   localparam logic MEM_ADR_PC   = 1'b1;

   localparam logic RWA_RI = 1'b0;
   localparam logic RWA_R0 = 1'b1;

   localparam logic [2:0] RWS_NOT_DATA2 = 3'b000;
   localparam logic [2:0] RWS_ALU_REG   = 3'b001;
   localparam logic [2:0] RWS_DATA2     = 3'b010;
   localparam logic [2:0] RWS_R0        = 3'b011;
   localparam logic [2:0] RWS_MDR       = 3'b100;

   localparam logic SRCA_R0 = 1'b0;
   localparam logic SRCA_PC = 1'b1;

   localparam logic [1:0] SRCB_IMM   = 2'b00;
   localparam logic [1:0] SRCB_ONE   = 2'b01;
   localparam logic [1:0] SRCB_DATA2 = 2'b10;

   localparam logic [1:0] PCS_ALU_REG = 2'b00;
   localparam logic [1:0] PCS_BRANCH  = 2'b01;
   localparam logic [1:0] PCS_JUMP    = 2'b10;
   localparam logic [1:0] PCS_ALU_OUT = 2'b11;

endpackage

// File: rtl/mips_controller_if.sv
// rtl/mips_controller_if.sv - instruction input and control strobes between controller and datapath
// Purpose: bundles inst_bus and every control output of mips_controller.
// Ports:   master = controller (reads inst_bus, drives controls);
//          slave  = datapath  (drives inst_bus, reads controls).
interface mips_controller_if;
   logic [15:0] inst_bus;
   logic        pc_write;
   logic        pc_write_cond;
   logic        mem_read;
   logic        mem_write;
   logic        IR_write;
   logic        reg_write_en;
   logic        mem_adr_sel;
   logic        reg_write_adr_sel;
   logic [2:0]  reg_write_sel;
   logic        ALU_src_A_sel;
   logic [1:0]  ALU_src_B_sel;
   logic [1:0]  pc_sel;
   logic [1:0]  ALU_op_code;

   modport master (
      input  inst_bus,
      output pc_write, pc_write_cond, mem_read, mem_write, IR_write,
             reg_write_en, mem_adr_sel, reg_write_adr_sel, reg_write_sel,
             ALU_src_A_sel, ALU_src_B_sel, pc_sel, ALU_op_code
   );

   modport slave (
      output inst_bus,
      input  pc_write, pc_write_cond, mem_read, mem_write, IR_write,
             reg_write_en, mem_adr_sel, reg_write_adr_sel, reg_write_sel,
             ALU_src_A_sel, ALU_src_B_sel, pc_sel, ALU_op_code
   );
endinterface

// File: rtl/mips_controller_alu_ctrl.sv
// rtl/mips_controller_alu_ctrl.sv - combinational ALU operation select
// Purpose: maps the state class plus function/opcode fields to ALU_op_code.
// Ports:   alu_class (in, 3), func (in, 3), opcode (in, 4), alu_op_code (out, 2).
module alu_ctrl
   import mips_ctrl_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [2:0]  func,
   input  logic [3:0]  opcode,
   output logic [1:0]  alu_op_code
);

   always_comb begin
      alu_op_code = ALU_ADD;
      case (alu_class)
         ALU_CLS_FETCH: alu_op_code = ALU_ADD;
         ALU_CLS_BRZ:   alu_op_code = ALU_PASS_A;
         ALU_CLS_C: begin
            // Moves, NOT and NOP do not use the ALU result; leave it at ADD.
            case (func)
               FN_SUB:  alu_op_code = ALU_SUB;
               FN_AND:  alu_op_code = ALU_AND;
               default: alu_op_code = ALU_ADD;
            endcase
         end
         ALU_CLS_I: begin
            case (opcode)
               OP_SUBI: alu_op_code = ALU_SUB;
               OP_ANDI: alu_op_code = ALU_AND;
               default: alu_op_code = ALU_ADD;
            endcase
         end
         default: alu_op_code = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - multi-cycle Moore control FSM for a 16-bit MIPS-like datapath
// Purpose: sequences fetch/decode/execute/writeback and drives datapath controls.
// Ports:   clk (in, 1), rst (in, 1, sync active-high),
//          bus (mips_controller_if.master: inst_bus in, control strobes out).
module mips_controller
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   mips_controller_if.master   bus
);

   state_t      state;
   state_t      state_next;
   alu_class_t  alu_class;
   logic [1:0]  alu_op;
   logic [3:0]  opcode;
   logic [2:0]  func;

   assign opcode = bus.inst_bus[15:12];
   assign func   = bus.inst_bus[2:0];

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH: state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD:  state_next = S_MEM_RD;
               OP_STORE: state_next = S_MEM_WR;
               OP_JUMP:  state_next = S_JMP;
               OP_BRZ:   state_next = S_BRZ;
               OP_CTYPE: state_next = S_C_EXEC;
               OP_ADDI, OP_SUBI, OP_ANDI: state_next = S_I_EXEC;
               default:  state_next = S_FETCH;
            endcase
         end
         S_MEM_RD: state_next = S_LOAD_WB;
         S_C_EXEC: state_next = S_C_WB;
         S_I_EXEC: state_next = S_I_WB;
         default:  state_next = S_FETCH;
      endcase
   end

   alu_ctrl u_alu_ctrl (
      .alu_class   (alu_class),
      .func        (func),
      .opcode      (opcode),
      .alu_op_code (alu_op)
   );

   // Outputs are forced low while rst is high, even before the state register
   // has been pulled back to FETCH by the next clock edge.
   always_comb begin
      bus.pc_write          = 1'b0;
      bus.pc_write_cond     = 1'b0;
      bus.mem_read          = 1'b0;
      bus.mem_write         = 1'b0;
      bus.IR_write          = 1'b0;
      bus.reg_write_en      = 1'b0;
      bus.mem_adr_sel       = MEM_ADR_INST;
      bus.reg_write_adr_sel = RWA_RI;
      bus.reg_write_sel     = RWS_NOT_DATA2;
      bus.ALU_src_A_sel     = SRCA_R0;
      bus.ALU_src_B_sel     = SRCB_IMM;
      bus.pc_sel            = PCS_ALU_REG;
      alu_class             = ALU_CLS_NONE;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               bus.mem_read      = 1'b1;
               bus.mem_adr_sel   = MEM_ADR_PC;
               bus.IR_write      = 1'b1;
               bus.ALU_src_A_sel = SRCA_PC;
               bus.ALU_src_B_sel = SRCB_ONE;
               bus.pc_sel        = PCS_ALU_OUT;
               bus.pc_write      = 1'b1;
               alu_class         = ALU_CLS_FETCH;
            end
            S_MEM_RD: bus.mem_read = 1'b1;
            S_LOAD_WB: begin
               bus.reg_write_en      = 1'b1;
               bus.reg_write_adr_sel = RWA_R0;
               bus.reg_write_sel     = RWS_MDR;
            end
            S_MEM_WR: bus.mem_write = 1'b1;
            S_JMP: begin
               bus.pc_sel   = PCS_JUMP;
               bus.pc_write = 1'b1;
            end
            S_BRZ: begin
               // ALU passes R0 through; the datapath gates the PC load on zero.
               bus.pc_sel        = PCS_BRANCH;
               bus.pc_write_cond = 1'b1;
               alu_class         = ALU_CLS_BRZ;
            end
            S_C_EXEC: begin
               bus.ALU_src_B_sel = SRCB_DATA2;
               alu_class         = ALU_CLS_C;
            end
            S_C_WB: begin
               case (func)
                  FN_ADD, FN_SUB, FN_AND: begin
                     bus.reg_write_en      = 1'b1;
                     bus.reg_write_adr_sel = RWA_R0;
                     bus.reg_write_sel     = RWS_ALU_REG;
                  end
                  FN_MOVEFROM: begin
                     bus.reg_write_en      = 1'b1;
                     bus.reg_write_adr_sel = RWA_R0;
                     bus.reg_write_sel     = RWS_DATA2;
                  end
                  FN_NOT: begin
                     bus.reg_write_en      = 1'b1;
                     bus.reg_write_adr_sel = RWA_R0;
                     bus.reg_write_sel     = RWS_NOT_DATA2;
                  end
                  FN_MOVETO: begin
                     bus.reg_write_en      = 1'b1;
                     bus.reg_write_adr_sel = RWA_RI;
                     bus.reg_write_sel     = RWS_R0;
                  end
                  default: ;
               endcase
            end
            S_I_EXEC: alu_class = ALU_CLS_I;
            S_I_WB: begin
               bus.reg_write_en      = 1'b1;
               bus.reg_write_adr_sel = RWA_R0;
               bus.reg_write_sel     = RWS_ALU_REG;
            end
            default: ;
         endcase
      end
   end

   assign bus.ALU_op_code = alu_op;

endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 inst_bus  in  16  IR contents; opcode [15:12], Ri [11:9], function [2:0].
REQ-005 pc_write  out  1  unconditional PC load.
REQ-006 pc_write_cond  out  1  PC load when ALU zero flag is set.
REQ-007 mem_read, mem_write  out  1 each  memory read and write strobes.
REQ-008 IR_write  out  1  IR load.
REQ-009 reg_write_en  out  1  register-file write.
REQ-010 mem_adr_sel  out  1  0=inst[11:0], 1=PC.
REQ-011 reg_write_adr_sel  out  1  0=Ri, 1=R0.
REQ-012 reg_write_sel  out  3  000=~data2, 001=ALU result reg, 010=data2, 011=R0, 100=MDR.
REQ-013 ALU_src_A_sel  out  1  0=R0, 1=PC (sign-extended).
REQ-014 ALU_src_B_sel  out  2  00=sext imm, 01=const 1, 10=data2.
REQ-015 pc_sel  out  2  00=ALU result reg, 01=branch target, 10=jump target, 11=live ALU out.
REQ-016 ALU_op_code  out  2  00=ADD, 01=SUB, 10=AND, 11=PASS_A.

Function
REQ-017 The block SHALL be a Moore FSM; all outputs SHALL decode from state and inst_bus only.
REQ-018 Every output SHALL be 0 in any state that does not assert it.
REQ-019 Opcode map SHALL be: 0000 LOAD, 0001 STORE, 0010 JUMP, 0100 BRZ, 1000 C-type, 1100 ADDI, 1101 SUBI, 1110 ANDI.
REQ-020 C-type functions SHALL be: 000 MOVETO (Ri<-R0), 001 MOVEFROM (R0<-Ri), 010 ADD, 011 SUB, 100 AND, 101 NOT (R0<-~Ri), 110/111 NOP.
REQ-021 FETCH SHALL assert mem_read, mem_adr_sel=1, IR_write, A=PC, B=1, ADD, pc_sel=11 and pc_write; next state is DECODE.
REQ-022 DECODE SHALL assert no output and SHALL branch on opcode; undefined opcodes SHALL return to FETCH.
REQ-023 LOAD SHALL run MEM_RD (mem_read, mem_adr_sel=0), then LOAD_WB (reg_write_en, adr_sel=1, write_sel=100), then FETCH.
REQ-024 STORE SHALL run MEM_WR (mem_write, mem_adr_sel=0), then FETCH.
REQ-025 JUMP SHALL run JMP (pc_sel=10, pc_write), then FETCH.
REQ-026 BRZ SHALL run BRZ (A=R0, PASS_A, pc_sel=01, pc_write_cond), then FETCH; the branch is taken only when R0==0.
REQ-027 C-type SHALL run C_EXEC (A=R0, B=10, op per function), then C_WB, then FETCH.
REQ-028 C_WB writes SHALL be: ALU ops to R0 from 001; MOVEFROM to R0 from 010; NOT to R0 from 000; MOVETO to Ri from 011; NOP SHALL write nothing.
REQ-029 I-type SHALL run I_EXEC (A=R0, B=00, ADD/SUB/AND), then I_WB (R0 from 001), then FETCH.
REQ-030 Latency in cycles SHALL be: LOAD 4, STORE 3, JUMP 3, BRZ 3, C 4, I 4, undefined 2.
REQ-031 pc_write and pc_write_cond SHALL never be asserted in the same cycle; mem_read and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-032 While rst is high, all outputs SHALL be 0 and state SHALL load FETCH; this holds even when rst is asserted mid-instruction.
REQ-033 The first cycle after rst falls SHALL be FETCH.

Structure
REQ-034 Package mips_ctrl_pkg SHALL hold the state enum, opcodes, function codes, ALU op codes and all selector encodings.
REQ-035 Sub-module alu_ctrl SHALL combinationally map state class and function or opcode to ALU_op_code.

Verification
REQ-036 Reset then release: cycle 1 shows FETCH outputs (mem_read=1, IR_write=1, pc_write=1, pc_sel=11); all outputs are 0 during rst.
REQ-037 inst_bus=16'h0123 (LOAD): states FETCH, DECODE, MEM_RD, LOAD_WB; LOAD_WB shows reg_write_en=1, write_sel=100, adr_sel=1.
REQ-038 inst_bus=16'h4005 (BRZ): the BRZ cycle shows pc_write_cond=1, pc_sel=01, ALU_op_code=11, pc_write=0.
REQ-039 inst_bus=16'h8600 (MOVETO R3): C_WB shows reg_write_en=1, adr_sel=0, write_sel=011; with 16'h8007 (NOP), reg_write_en stays 0.
REQ-040 inst_bus=16'hF000 (undefined): DECODE is followed directly by FETCH; asserting rst during C_EXEC forces FETCH with all outputs 0.
